// File: rtl/dp_ram_param.sv
// dp_ram_param: true dual-port synchronous RAM with per-byte write enables,
// registered reads, a hardware zero-fill sweep after reset or on clr_req, and
// same-address write arbitration (port A wins overlapping byte lanes).
// Port A serves the core LSU, port B the debug/DMA master.
// Optional feature: define DPRAM_COL_CNT_EN to build the saturating 16-bit
// collision counter; otherwise col_cnt is tied to zero and has no flops.
module dp_ram_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned RDW_MODE = 0,
  localparam int unsigned NB      = DATA_W / 8,
  localparam int unsigned DEPTH   = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              init_done,
  // port A
  input  logic              a_req,
  input  logic              a_we,
  input  logic [NB-1:0]     a_be,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ready,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  // port B
  input  logic              b_req,
  input  logic              b_we,
  input  logic [NB-1:0]     b_be,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ready,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  // collision reporting
  output logic              col_err,
  output logic [15:0]       col_cnt
);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              run;
  logic              a_rd, a_wr, b_rd, b_wr;
  logic              same_addr;
  logic [NB-1:0]     a_wen, b_wen;
  logic [DATA_W-1:0] a_old, b_old;
  logic [DATA_W-1:0] a_merged, b_merged;

  logic              a_rvalid_q, a_rvalid_d;
  logic              b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic              col_err_q, col_err_d;

  // Old word with the enabled byte lanes replaced by the new data.
  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [NB-1:0]     be);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Sweep / run FSM
  // ---------------------------------------------------------------------------

  // State and sweep pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StClear;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Next state: sweep every word once, then run until a clear is requested.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      StClear: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (&clr_ptr_q) state_d = StRun;
      end
      StRun: begin
        if (clr_req) begin
          state_d   = StClear;
          clr_ptr_d = '0;
        end
      end
      default: state_d = StClear;
    endcase
  end

  // FSM outputs: array is usable only in RUN.
  always_comb begin
    init_done = (state_q == StRun);
  end

  assign run     = init_done;
  assign a_ready = init_done;
  assign b_ready = init_done;

  // ---------------------------------------------------------------------------
  // Access decode and arbitration
  // ---------------------------------------------------------------------------

  assign a_wr      = run & a_req & a_we;
  assign a_rd      = run & a_req & ~a_we;
  assign b_wr      = run & b_req & b_we;
  assign b_rd      = run & b_req & ~b_we;
  assign same_addr = (a_addr == b_addr);

  assign a_old    = mem[a_addr];
  assign b_old    = mem[b_addr];
  assign a_merged = byte_merge(a_old, a_wdata, a_be);
  assign b_merged = byte_merge(b_old, b_wdata, b_be);

  // Lane enables; on a same-address double write B loses the lanes A also owns.
  always_comb begin
    a_wen = a_wr ? a_be : '0;
    b_wen = b_wr ? b_be : '0;
    if (a_wr && same_addr) b_wen = b_wen & ~a_be;
  end

  // Array update: zero-fill during the sweep, byte-lane writes in RUN.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem[clr_ptr_q] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (a_wen[i]) mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
        if (b_wen[i]) mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read data path
  // ---------------------------------------------------------------------------

  // Next read data: reads return the pre-edge word; writes return old or merged word.
  always_comb begin
    a_rvalid_d = a_rd;
    b_rvalid_d = b_rd;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    if (a_rd) a_rdata_d = a_old;
    else if (a_wr) a_rdata_d = (RDW_MODE == 1) ? a_merged : a_old;
    if (b_rd) b_rdata_d = b_old;
    else if (b_wr) b_rdata_d = (RDW_MODE == 1) ? b_merged : b_old;
    col_err_d = a_wr & b_wr & same_addr & (|(a_be & b_be));
  end

  // Registered read outputs and collision pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      col_err_q  <= 1'b0;
    end else begin
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      col_err_q  <= col_err_d;
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign col_err  = col_err_q;

  // ---------------------------------------------------------------------------
  // Collision counter
  // ---------------------------------------------------------------------------

`ifdef DPRAM_COL_CNT_EN
  logic [15:0] col_cnt_q;

  // Saturating count of collision pulses; only rst_n clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt_q <= '0;
    end else if (col_err_d && (col_cnt_q != 16'hFFFF)) begin
      col_cnt_q <= col_cnt_q + 16'd1;
    end
  end

  assign col_cnt = col_cnt_q;
`else
  assign col_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_dp_ram_param.sv
// Self-checking bench for dp_ram_param: two instances (RDW_MODE 0 and 1) share
// stimulus; a word-array model predicts every registered output each cycle.
module tb_dp_ram_param;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr_req = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [3:0]  a_be = '0, b_be = '0;
  logic [9:0]  a_addr = '0, b_addr = '0;
  logic [31:0] a_wdata = '0, b_wdata = '0;

  logic        init_done0, a_ready0, b_ready0, a_rvalid0, b_rvalid0, col_err0;
  logic [31:0] a_rdata0, b_rdata0;
  logic [15:0] col_cnt0;
  logic        init_done1, a_ready1, b_ready1, a_rvalid1, b_rvalid1, col_err1;
  logic [31:0] a_rdata1, b_rdata1;
  logic [15:0] col_cnt1;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  dp_ram_param #(.DATA_W(32), .ADDR_W(10), .RDW_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .init_done(init_done0),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready0), .a_rvalid(a_rvalid0), .a_rdata(a_rdata0),
    .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready0), .b_rvalid(b_rvalid0), .b_rdata(b_rdata0),
    .col_err(col_err0), .col_cnt(col_cnt0)
  );

  dp_ram_param #(.DATA_W(32), .ADDR_W(10), .RDW_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .init_done(init_done1),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready1), .a_rvalid(a_rvalid1), .a_rdata(a_rdata1),
    .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready1), .b_rvalid(b_rvalid1), .b_rdata(b_rdata1),
    .col_err(col_err1), .col_cnt(col_cnt1)
  );

  // ---------------- behavioural model ----------------
  logic [31:0] mm [DEPTH];
  int          busy;
  logic        e_arv, e_brv, e_col;
  logic [31:0] e_ard0, e_ard1, e_brd0, e_brd1;
  logic [15:0] e_cnt;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  // Contents are unobservable while sweeping, so the model zeroes the array up front.
  always @(posedge clk or negedge rst_n) begin
    logic [31:0] old_a, old_b;
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mm[i] = '0;
      busy = DEPTH;
      e_arv = 0; e_brv = 0; e_col = 0; e_cnt = '0;
      e_ard0 = '0; e_ard1 = '0; e_brd0 = '0; e_brd1 = '0;
    end else if (busy != 0) begin
      busy--;
      e_arv = 0; e_brv = 0; e_col = 0;
    end else begin
      old_a = mm[a_addr];
      old_b = mm[b_addr];
      e_arv = a_req && !a_we;
      e_brv = b_req && !b_we;
      if (a_req) begin
        e_ard0 = old_a;
        e_ard1 = a_we ? merge(old_a, a_wdata, a_be) : old_a;
      end
      if (b_req) begin
        e_brd0 = old_b;
        e_brd1 = b_we ? merge(old_b, b_wdata, b_be) : old_b;
      end
      e_col = a_req && a_we && b_req && b_we && (a_addr == b_addr) && ((a_be & b_be) != 0);
`ifdef DPRAM_COL_CNT_EN
      if (e_col && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
`endif
      // B first, then A, so A owns any shared lane.
      if (b_req && b_we) mm[b_addr] = merge(mm[b_addr], b_wdata, b_be);
      if (a_req && a_we) mm[a_addr] = merge(mm[a_addr], a_wdata, a_be);
      if (clr_req) begin
        for (int i = 0; i < DEPTH; i++) mm[i] = '0;
        busy = DEPTH;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("init_done0", {31'b0, init_done0}, {31'b0, busy == 0});
      check("init_done1", {31'b0, init_done1}, {31'b0, busy == 0});
      check("a_ready", {31'b0, a_ready0}, {31'b0, busy == 0});
      check("b_ready", {31'b0, b_ready1}, {31'b0, busy == 0});
      check("a_rvalid0", {31'b0, a_rvalid0}, {31'b0, e_arv});
      check("b_rvalid0", {31'b0, b_rvalid0}, {31'b0, e_brv});
      check("a_rvalid1", {31'b0, a_rvalid1}, {31'b0, e_arv});
      check("b_rvalid1", {31'b0, b_rvalid1}, {31'b0, e_brv});
      check("col_err0", {31'b0, col_err0}, {31'b0, e_col});
      check("col_err1", {31'b0, col_err1}, {31'b0, e_col});
      check("col_cnt0", {16'b0, col_cnt0}, {16'b0, e_cnt});
      check("col_cnt1", {16'b0, col_cnt1}, {16'b0, e_cnt});
      check("a_rdata1", a_rdata1, e_ard1);
      check("b_rdata1", b_rdata1, e_brd1);
      if (e_arv) check("a_rdata0", a_rdata0, e_ard0);
      if (e_brv) check("b_rdata0", b_rdata0, e_brd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic ar, input logic aw, input logic [3:0] abe,
                     input logic [9:0] aa, input logic [31:0] ad,
                     input logic br, input logic bw, input logic [3:0] bbe,
                     input logic [9:0] ba, input logic [31:0] bd, input logic clr);
    a_req = ar; a_we = aw; a_be = abe; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_be = bbe; b_addr = ba; b_wdata = bd;
    clr_req = clr;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 4'h0, 10'h0, 32'h0, 0, 0, 4'h0, 10'h0, 32'h0, 0);
  endtask

  // Counts cycles with init_done low after the caller releases reset.
  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (!init_done0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, n, 1024);
  endtask

  initial begin
    // 1: reset, sweep length, cleared contents
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_init_done", {31'b0, init_done0}, 32'h0);
    check("reset_rdata", a_rdata0, 32'h0);
    rst_n = 1'b1;
    wait_init("sweep_len_1");
    cyc(1, 0, 4'h0, 10'h155, 32'h0, 1, 0, 4'h0, 10'h2AA, 32'h0, 0);
    check("t1_a_rvalid", {31'b0, a_rvalid0}, 32'h1);
    check("t1_a_rdata", a_rdata0, 32'h0);
    check("t1_b_rdata", b_rdata0, 32'h0);
    idle();
    check("t1_rvalid_drop", {31'b0, a_rvalid0}, 32'h0);

    // 2: top address write/read, wrap address untouched
    cyc(1, 1, 4'hF, 10'h3FF, 32'hDEADBEEF, 0, 0, 4'h0, 10'h0, 32'h0, 0);
    check("t2_wr_no_rvalid", {31'b0, a_rvalid0}, 32'h0);
    cyc(1, 0, 4'h0, 10'h3FF, 32'h0, 0, 0, 4'h0, 10'h0, 32'h0, 0);
    check("t2_rvalid", {31'b0, a_rvalid0}, 32'h1);
    check("t2_rdata", a_rdata0, 32'hDEADBEEF);
    cyc(1, 0, 4'h0, 10'h000, 32'h0, 0, 0, 4'h0, 10'h0, 32'h0, 0);
    check("t2_wrap_zero", a_rdata0, 32'h0);

    // 3: partial byte write, merged RDW on the mode-1 instance
    cyc(1, 1, 4'hF, 10'h010, 32'hAAAAAAAA, 0, 0, 4'h0, 10'h0, 32'h0, 0);
    cyc(1, 1, 4'b0011, 10'h010, 32'h11223344, 0, 0, 4'h0, 10'h0, 32'h0, 0);
    check("t3_rdw1_merged", a_rdata1, 32'hAAAA3344);
    check("t3_rdw0_old", a_rdata0, 32'hAAAAAAAA);
    cyc(1, 1, 4'b0000, 10'h010, 32'hFFFFFFFF, 0, 0, 4'h0, 10'h0, 32'h0, 0);
    cyc(1, 0, 4'h0, 10'h010, 32'h0, 0, 0, 4'h0, 10'h0, 32'h0, 0);
    check("t3_read", a_rdata0, 32'hAAAA3344);

    // 4: same-address double write with overlapping lane
    cyc(1, 1, 4'b0001, 10'h020, 32'h000000AA, 1, 1, 4'b0011, 10'h020, 32'h0000BBCC, 0);
    check("t4_col_err", {31'b0, col_err0}, 32'h1);
`ifdef DPRAM_COL_CNT_EN
    check("t4_col_cnt", {16'b0, col_cnt0}, 32'h1);
`else
    check("t4_col_cnt", {16'b0, col_cnt0}, 32'h0);
`endif
    cyc(1, 0, 4'h0, 10'h020, 32'h0, 0, 0, 4'h0, 10'h0, 32'h0, 0);
    check("t4_col_err_drop", {31'b0, col_err0}, 32'h0);
    check("t4_mem", a_rdata0, 32'h0000BBAA);

    // 5: cross-port write/read returns old data
    cyc(1, 1, 4'hF, 10'h030, 32'h7, 0, 0, 4'h0, 10'h0, 32'h0, 0);
    cyc(1, 1, 4'hF, 10'h030, 32'h5, 1, 0, 4'h0, 10'h030, 32'h0, 0);
    check("t5_b_old", b_rdata0, 32'h7);
    cyc(0, 0, 4'h0, 10'h0, 32'h0, 1, 0, 4'h0, 10'h030, 32'h0, 0);
    check("t5_b_new", b_rdata0, 32'h5);

    // Random traffic on a narrow address window to provoke collisions.
    for (int i = 0; i < 3000; i++) begin
      logic [9:0] base;
      base = ($urandom_range(0, 1) != 0) ? 10'h3F0 : 10'h000;
      cyc(($urandom_range(0, 3) != 0), $urandom_range(0, 1), 4'($urandom),
          base | 10'($urandom_range(0, 7)), $urandom,
          ($urandom_range(0, 3) != 0), $urandom_range(0, 1), 4'($urandom),
          base | 10'($urandom_range(0, 7)), $urandom, (i == 1500));
    end

    // 6: clear request, reset mid-sweep restarts a full sweep
    cyc(0, 0, 4'h0, 10'h0, 32'h0, 0, 0, 4'h0, 10'h0, 32'h0, 1);
    repeat (499) idle();
    check("t6_mid_sweep", {31'b0, init_done0}, 32'h0);
    rst_n = 1'b0;
    repeat (2) idle();
    rst_n = 1'b1;
    wait_init("sweep_len_2");
    check("t6_col_cnt", {16'b0, col_cnt0}, 32'h0);
    cyc(1, 0, 4'h0, 10'h3FF, 32'h0, 1, 0, 4'h0, 10'h010, 32'h0, 0);
    check("t6_a_zero", a_rdata0, 32'h0);
    check("t6_b_zero", b_rdata0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 4'h0, 10'($urandom), 32'h0, 1, 0, 4'h0, 10'h3F0 | 10'(i), 32'h0, 0);
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
